// File: rtl/ram_pkg.sv
// Shared types and helpers for the simple-dual-port init RAM.
package ram_pkg;

    // Sweep/run control state
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } st_e;

    // Widest word the byte-merge helper supports; callers cast in and out
    localparam int unsigned MERGE_W    = 64;
    localparam int unsigned MERGE_BE_W = MERGE_W / 8;

    // Replace the bytes of old_w selected by be with the matching bytes of new_w
    function automatic logic [MERGE_W-1:0] merge(
        input logic [MERGE_W-1:0]    old_w,
        input logic [MERGE_W-1:0]    new_w,
        input logic [MERGE_BE_W-1:0] be
    );
        logic [MERGE_W-1:0]    res;
        logic [MERGE_W-1:0]    mask;
        logic [MERGE_BE_W-1:0] bsh;
        res = old_w;
        for (int unsigned i = 0; i < MERGE_BE_W; i++) begin
            bsh  = be >> i;
            mask = MERGE_W'(8'hFF) << (8 * i);
            if (bsh[0]) begin
                res = (res & ~mask) | (new_w & mask);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_sdp_init_if.sv
// Port bundle for ram_sdp_init: write port, read port, control and status.
interface ram_sdp_init_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
);
    logic                  CS;
    logic                  clr;
    logic                  WE;
    logic [ADDR_W-1:0]     wAddr;
    logic [DATA_W-1:0]     wData;
    logic [DATA_W/8-1:0]   wBe;
    logic                  RE;
    logic [ADDR_W-1:0]     rAddr;
    logic [DATA_W-1:0]     dataOut;
    logic                  rValid;
    logic                  ready;
    logic                  wErr;

    modport master (
        output CS, clr, WE, wAddr, wData, wBe, RE, rAddr,
        input  dataOut, rValid, ready, wErr
    );

    modport slave (
        input  CS, clr, WE, wAddr, wData, wBe, RE, rAddr,
        output dataOut, rValid, ready, wErr
    );
endinterface

// File: rtl/ram_rd_pipe.sv
// Read data/valid register chain, RD_LAT stages deep; data only moves with its valid bit.
module ram_rd_pipe #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_dat,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_dat
);
    logic [RD_LAT-1:0] vld_q;
    logic [DATA_W-1:0] dat_q [RD_LAT];

    // First stage captures the array word when a read is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q[0] <= 1'b0;
            dat_q[0] <= '0;
        end else begin
            vld_q[0] <= in_vld;
            if (in_vld) begin
                dat_q[0] <= in_dat;
            end
        end
    end

    for (genvar g = 1; g < RD_LAT; g++) begin : g_stage
        // Later stages forward data only behind a valid bit, otherwise hold
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q[g] <= 1'b0;
                dat_q[g] <= '0;
            end else begin
                vld_q[g] <= vld_q[g-1];
                if (vld_q[g-1]) begin
                    dat_q[g] <= dat_q[g-1];
                end
            end
        end
    end

    assign out_vld = vld_q[RD_LAT-1];
    assign out_dat = dat_q[RD_LAT-1];

endmodule

// File: rtl/ram_sdp_init.sv
// Simple-dual-port RAM with byte enables, hardware init sweep and registered reads.
module ram_sdp_init
    import ram_pkg::*;
#(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       ADDR_W   = 3,
    parameter logic [DATA_W-1:0] INIT_VAL = '0,
    parameter int unsigned       RD_LAT   = 1,
    parameter bit                RDW_NEW  = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    ram_sdp_init_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    st_e               state;
    logic [ADDR_W-1:0] cnt;
    logic              ready_q;
    logic              werr_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_ok;
    logic              rd_ok;
    logic              drop;
    logic [DATA_W-1:0] rd_old;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] rd_word;

    // Requests are honoured only once the sweep is done and the chip is selected
    assign wr_ok = ready_q & bus.CS & bus.WE;
    assign rd_ok = ready_q & bus.CS & bus.RE;
    assign drop  = (bus.WE | bus.RE) & ~(ready_q & bus.CS);

    // Merged write word; doubles as the new-data bypass on a same-address read
    assign rd_old  = mem[bus.rAddr];
    assign wr_word = DATA_W'(merge(MERGE_W'(mem[bus.wAddr]), MERGE_W'(bus.wData),
                                   MERGE_BE_W'(bus.wBe)));
    assign rd_word = (RDW_NEW && wr_ok && (bus.wAddr == bus.rAddr)) ? wr_word : rd_old;

    // Sweep/run FSM with registered ready and drop pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_INIT;
            cnt     <= '0;
            ready_q <= 1'b0;
            werr_q  <= 1'b0;
        end else begin
            werr_q <= drop;
            case (state)
                ST_INIT: begin
                    if (bus.clr) begin
                        cnt <= '0;
                    end else if (cnt == ADDR_W'(DEPTH - 1)) begin
                        cnt     <= '0;
                        state   <= ST_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                ST_RUN: begin
                    if (bus.clr) begin
                        cnt     <= '0;
                        state   <= ST_INIT;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    cnt     <= '0;
                    state   <= ST_INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Array write: sweep fills INIT_VAL, otherwise byte-enabled port write
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[cnt] <= INIT_VAL;
        end else if (wr_ok) begin
            mem[bus.wAddr] <= wr_word;
        end
    end

    ram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (rd_ok),
        .in_dat  (rd_word),
        .out_vld (bus.rValid),
        .out_dat (bus.dataOut)
    );

    assign bus.ready = ready_q;
    assign bus.wErr  = werr_q;

endmodule

// File: tb/tb_ram_sdp_init.sv
// Directed bench: dut_a (RD_LAT=1, old-data RDW), dut_b (RD_LAT=2, new-data RDW) share
// stimulus; dut_c is a 16-bit instance for byte-enable merging.
module tb_ram_sdp_init;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    ram_sdp_init_if #(.DATA_W(8),  .ADDR_W(3)) ifa ();
    ram_sdp_init_if #(.DATA_W(8),  .ADDR_W(3)) ifb ();
    ram_sdp_init_if #(.DATA_W(16), .ADDR_W(3)) ifc ();

    ram_sdp_init #(.DATA_W(8), .ADDR_W(3), .INIT_VAL(8'hA5), .RD_LAT(1), .RDW_NEW(1'b0))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    ram_sdp_init #(.DATA_W(8), .ADDR_W(3), .INIT_VAL(8'hA5), .RD_LAT(2), .RDW_NEW(1'b1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    ram_sdp_init #(.DATA_W(16), .ADDR_W(3), .INIT_VAL(16'h0000), .RD_LAT(1), .RDW_NEW(1'b0))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    // dut_b sees exactly the same requests as dut_a
    assign ifb.CS    = ifa.CS;
    assign ifb.clr   = ifa.clr;
    assign ifb.WE    = ifa.WE;
    assign ifb.wAddr = ifa.wAddr;
    assign ifb.wData = ifa.wData;
    assign ifb.wBe   = ifa.wBe;
    assign ifb.RE    = ifa.RE;
    assign ifb.rAddr = ifa.rAddr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Read on a/b: a returns after 1 edge, b after 2 edges
    task automatic rd(input logic [2:0] addr, input logic [7:0] exp_a, input logic [7:0] exp_b);
        ifa.CS = 1'b1; ifa.RE = 1'b1; ifa.rAddr = addr;
        tick();
        ifa.RE = 1'b0;
        chk("rd_vld_a",   32'(ifa.rValid),  32'(1));
        chk("rd_data_a",  32'(ifa.dataOut), 32'(exp_a));
        chk("rd_vld_b0",  32'(ifb.rValid),  32'(0));
        tick();
        chk("rd_vld_a1",  32'(ifa.rValid),  32'(0));
        chk("rd_hold_a",  32'(ifa.dataOut), 32'(exp_a));
        chk("rd_vld_b",   32'(ifb.rValid),  32'(1));
        chk("rd_data_b",  32'(ifb.dataOut), 32'(exp_b));
    endtask

    task automatic wr(input logic [2:0] addr, input logic [7:0] data);
        ifa.CS = 1'b1; ifa.WE = 1'b1; ifa.wAddr = addr; ifa.wData = data; ifa.wBe = 1'b1;
        tick();
        ifa.WE = 1'b0;
        chk("wr_werr_a", 32'(ifa.wErr), 32'(0));
    endtask

    task automatic wrc(input logic [2:0] addr, input logic [15:0] data, input logic [1:0] be);
        ifc.CS = 1'b1; ifc.WE = 1'b1; ifc.wAddr = addr; ifc.wData = data; ifc.wBe = be;
        tick();
        ifc.WE = 1'b0;
        chk("wr_werr_c", 32'(ifc.wErr), 32'(0));
    endtask

    task automatic rdc(input logic [2:0] addr, input logic [15:0] exp);
        ifc.CS = 1'b1; ifc.RE = 1'b1; ifc.rAddr = addr;
        tick();
        ifc.RE = 1'b0;
        chk("rd_vld_c",  32'(ifc.rValid),  32'(1));
        chk("rd_data_c", 32'(ifc.dataOut), 32'(exp));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        ifa.CS = 1'b0; ifa.clr = 1'b0; ifa.WE = 1'b0; ifa.wAddr = '0; ifa.wData = '0;
        ifa.wBe = '0;  ifa.RE = 1'b0;  ifa.rAddr = '0;
        ifc.CS = 1'b0; ifc.clr = 1'b0; ifc.WE = 1'b0; ifc.wAddr = '0; ifc.wData = '0;
        ifc.wBe = '0;  ifc.RE = 1'b0;  ifc.rAddr = '0;
        tick();
        tick();

        // Reset values
        chk("rst_dout_a",  32'(ifa.dataOut), 32'(0));
        chk("rst_vld_a",   32'(ifa.rValid),  32'(0));
        chk("rst_rdy_a",   32'(ifa.ready),   32'(0));
        chk("rst_werr_a",  32'(ifa.wErr),    32'(0));
        chk("rst_dout_b",  32'(ifb.dataOut), 32'(0));
        chk("rst_rdy_c",   32'(ifc.ready),   32'(0));

        // Sweep: ready low for 8 edges after release
        rst_n = 1'b1;
        ifa.CS = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("sweep_rdy_a", 32'(ifa.ready), 32'(i == 8));
            chk("sweep_rdy_b", 32'(ifb.ready), 32'(i == 8));
            chk("sweep_rdy_c", 32'(ifc.ready), 32'(i == 8));
        end

        // Every word holds INIT_VAL after the sweep
        for (int i = 0; i < 8; i++) rd(3'(i), 8'hA5, 8'hA5);

        // Write 30..37, read back in order
        for (int i = 0; i < 8; i++) wr(3'(i), 8'(30 + i));
        for (int i = 0; i < 8; i++) rd(3'(i), 8'(30 + i), 8'(30 + i));

        // Read-during-write at address 5
        wr(3'd5, 8'h11);
        ifa.WE = 1'b1; ifa.wAddr = 3'd5; ifa.wData = 8'h22; ifa.wBe = 1'b1;
        ifa.RE = 1'b1; ifa.rAddr = 3'd5;
        tick();
        ifa.WE = 1'b0; ifa.RE = 1'b0;
        chk("rdw_vld_a",  32'(ifa.rValid),  32'(1));
        chk("rdw_old_a",  32'(ifa.dataOut), 32'(8'h11));
        tick();
        chk("rdw_vld_b",  32'(ifb.rValid),  32'(1));
        chk("rdw_new_b",  32'(ifb.dataOut), 32'(8'h22));
        rd(3'd5, 8'h22, 8'h22);

        // Read with CS low is dropped; dataOut holds
        ifa.CS = 1'b0; ifa.RE = 1'b1; ifa.rAddr = 3'd0;
        tick();
        chk("cs0_vld_a",  32'(ifa.rValid),  32'(0));
        chk("cs0_hold_a", 32'(ifa.dataOut), 32'(8'h22));
        chk("cs0_werr_a", 32'(ifa.wErr),    32'(1));
        chk("cs0_werr_b", 32'(ifb.wErr),    32'(1));
        ifa.RE = 1'b0; ifa.CS = 1'b1;
        tick();
        chk("cs0_werr_a1", 32'(ifa.wErr),    32'(0));
        chk("cs0_vld_b",   32'(ifb.rValid),  32'(0));
        chk("cs0_hold_b",  32'(ifb.dataOut), 32'(8'h22));

        // clr in RUN restarts the sweep; a write to addr 0 during it is dropped
        ifa.clr = 1'b1;
        tick();
        ifa.clr = 1'b0;
        chk("clr_rdy_a", 32'(ifa.ready), 32'(0));
        chk("clr_rdy_b", 32'(ifb.ready), 32'(0));
        ifa.wAddr = 3'd0; ifa.wData = 8'h77; ifa.wBe = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            ifa.WE = (i == 2);
            tick();
            chk("clr_rdy_a",  32'(ifa.ready), 32'(i == 8));
            chk("clr_werr_a", 32'(ifa.wErr),  32'(i == 2));
            chk("clr_werr_b", 32'(ifb.wErr),  32'(i == 2));
        end
        ifa.WE = 1'b0;
        for (int i = 0; i < 8; i++) rd(3'(i), 8'hA5, 8'hA5);

        // Async reset mid-sweep (cnt=4) then a full rerun of the sweep
        ifa.clr = 1'b1;
        tick();
        ifa.clr = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dout_a", 32'(ifa.dataOut), 32'(0));
        chk("arst_vld_a",  32'(ifa.rValid),  32'(0));
        chk("arst_rdy_a",  32'(ifa.ready),   32'(0));
        chk("arst_dout_b", 32'(ifb.dataOut), 32'(0));
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("rerun_rdy_a", 32'(ifa.ready), 32'(i == 8));
            chk("rerun_rdy_c", 32'(ifc.ready), 32'(i == 8));
        end
        rd(3'd0, 8'hA5, 8'hA5);
        rd(3'd7, 8'hA5, 8'hA5);

        // 16-bit byte-enable merge
        rdc(3'd0, 16'h0000);
        wrc(3'd2, 16'h1234, 2'b11);
        wrc(3'd2, 16'hABCD, 2'b01);
        rdc(3'd2, 16'h12CD);
        wrc(3'd2, 16'hFFFF, 2'b00);
        rdc(3'd2, 16'h12CD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
